// File: rtl/stopwatch_pkg.sv
// Shared state encoding and helpers for the stopwatch control block.
package stopwatch_pkg;

    // Two-bit state code, exposed on the state output of the controller.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_LAP  = 2'd2;
    localparam state_t ST_STOP = 2'd3;

    // The counter advances in RUN and in LAP. The display only freezes in LAP.
    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one active-low push-button.
// The raw key goes through a 2-flop synchroniser and then a level filter.
// The output is a one-cycle press event.
// The delay from the raw level change to press is DB_CYCLES+3 clock edges.
module btn_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;        // debounced level, 1 = released
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_d;
    logic          press_q;

    // Bring the asynchronous key level into the clock domain.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DB_CYCLES consecutive cycles.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            db_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    // Register a one-cycle event on the released-to-pressed transition.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
        end else begin
            db_prev_q <= db_q;
            press_q   <= db_prev_q & ~db_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the MM:SS:hh stopwatch datapath.
// It produces the 100 Hz count tick, debounces the start/stop and lap/clear keys,
// and drives the enable, clear and freeze controls of the datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    output logic       tick,
    output logic       clear,
    output logic       freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]    btn_raw;
    logic [1:0]    press_ev;   // [0] = start/stop, [1] = lap/clear
    logic          start_ev;
    logic          lap_ev;

    state_t        state_q;
    state_t        state_d;
    logic          clear_q;
    logic          clear_d;
    logic          freeze_q;
    logic          freeze_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    assign btn_raw = {btn_lap_n, btn_start_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .CLOCK_50(CLOCK_50),
                .reset_n (reset_n),
                .btn_n   (btn_raw[gi]),
                .press   (press_ev[gi])
            );
        end
    endgenerate

    assign start_ev = press_ev[0];
    // If both keys fire in the same cycle, start/stop wins.
    assign lap_ev   = press_ev[1] & ~press_ev[0];

    // Next-state logic. A clear pulse is raised only when STOP returns to IDLE.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_ev)    state_d = ST_STOP;
                else if (lap_ev) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (start_ev)    state_d = ST_STOP;
                else if (lap_ev) state_d = ST_RUN;
            end
            ST_STOP: begin
                if (start_ev) begin
                    state_d = ST_RUN;
                end else if (lap_ev) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d == ST_LAP);
    end

    // Tick divider.
    // It counts while the FSM is counting, holds in STOP so a resume keeps the
    // sub-tick phase, and is zeroed in IDLE and on the cycle that enters IDLE.
    always_comb begin
        div_d = div_q;
        if (state_d == ST_IDLE) begin
            div_d = '0;
        end else if (is_counting(state_q)) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
    end

    // State, control strobes and divider registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            clear_q  <= 1'b0;
            freeze_q <= 1'b0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            clear_q  <= clear_d;
            freeze_q <= freeze_d;
            div_q    <= div_d;
        end
    end

    // tick is decoded from registers only, so a reset clears it at once.
    assign tick    = (div_q == DIV_LAST) && is_counting(state_q);
    assign running = is_counting(state_q);
    assign clear   = clear_q;
    assign freeze  = freeze_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DB_CYCLES=4.
// Expected tick edges go into a queue when the key that starts a run segment is driven.
// A negedge monitor pops and compares one entry for each tick the DUT produces.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int DBC    = 4;
    localparam int EV_LAT = DBC + 3;   // raw key change to press event
    localparam int DIVN   = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start_n = 1'b1;
    logic       btn_lap_n = 1'b1;
    logic       tick, clear, freeze, running;
    logic [1:0] state;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int exp_tick_q[$];

    stopwatch_ctrl #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .DB_CYCLES(DBC)
    ) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .btn_start_n(btn_start_n),
        .btn_lap_n  (btn_lap_n),
        .tick       (tick),
        .clear      (clear),
        .freeze     (freeze),
        .running    (running),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Count rising edges. At a negedge, cyc is the number of the edge just passed.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Press keys now and return the edge at which the FSM reacts.
    task automatic key_down(input bit s, input bit l, output int chg);
        if (s) btn_start_n = 1'b0;
        if (l) btn_lap_n = 1'b0;
        chg = cyc + EV_LAT + 1;
    endtask

    task automatic key_up(input bit s, input bit l);
        if (s) btn_start_n = 1'b1;
        if (l) btn_lap_n = 1'b1;
    endtask

    task automatic push_range(input int first, input int last);
        for (int t = first; t <= last; t += DIVN) exp_tick_q.push_back(t);
    endtask

    // Tick scoreboard. Each tick is tagged with the edge that consumes it.
    always @(negedge clk) begin
        int e;
        if (tick !== 1'b0) begin
            if (exp_tick_q.size() == 0) begin
                chk("tick_unexpected", {31'b0, tick}, 0);
            end else begin
                e = exp_tick_q.pop_front();
                chk("tick_edge", cyc + 1, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r1, s1, r2, la, lr, s2, r3, sb, k, r4, la4;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", {30'b0, state}, ST_IDLE);
        chk("rst_tick", {31'b0, tick}, 0);
        chk("rst_clear", {31'b0, clear}, 0);
        chk("rst_freeze", {31'b0, freeze}, 0);
        chk("rst_running", {31'b0, running}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {30'b0, state}, ST_IDLE);

        // Start from IDLE, then stop while div_cnt is 6
        c0 = cyc;
        key_down(1, 0, r1);
        push_range(r1 + 10, r1 + 47);
        wait_until(c0 + EV_LAT);
        chk("run_before_event", {31'b0, running}, 0);
        wait_until(r1);
        chk("run_rise", {31'b0, running}, 1);
        chk("run_state", {30'b0, state}, ST_RUN);
        chk("run_freeze", {31'b0, freeze}, 0);
        wait_until(c0 + 10);
        key_up(1, 0);
        wait_until(r1 + 39);
        key_down(1, 0, s1);
        wait_until(s1 - 1);
        chk("stop_pre", {30'b0, state}, ST_RUN);
        wait_until(s1);
        chk("stop_state", {30'b0, state}, ST_STOP);
        chk("stop_running", {31'b0, running}, 0);
        wait_until(r1 + 49);
        key_up(1, 0);
        wait_until(s1 + 50);
        chk("stop_hold", {30'b0, state}, ST_STOP);
        chk("tickq_a", exp_tick_q.size(), 0);

        // Resume, lap twice, then stop on a cycle that also carries a tick
        key_down(1, 0, r2);
        push_range(r2 + 3, r2 + 83);
        wait_until(r2);
        chk("resume_state", {30'b0, state}, ST_RUN);
        wait_until(r2 + 2);
        key_up(1, 0);
        wait_until(r2 + 20);
        key_down(0, 1, la);
        wait_until(la - 1);
        chk("lap_pre_freeze", {31'b0, freeze}, 0);
        wait_until(la);
        chk("lap_freeze", {31'b0, freeze}, 1);
        chk("lap_state", {30'b0, state}, ST_LAP);
        chk("lap_running", {31'b0, running}, 1);
        wait_until(r2 + 30);
        key_up(0, 1);
        wait_until(r2 + 48);
        key_down(0, 1, lr);
        wait_until(lr);
        chk("unlap_freeze", {31'b0, freeze}, 0);
        chk("unlap_state", {30'b0, state}, ST_RUN);
        wait_until(r2 + 58);
        key_up(0, 1);
        wait_until(r2 + 75);
        key_down(1, 0, s2);
        wait_until(s2);
        chk("stop2_state", {30'b0, state}, ST_STOP);
        chk("stop2_freeze", {31'b0, freeze}, 0);
        wait_until(r2 + 85);
        key_up(1, 0);
        wait_until(s2 + 3);
        chk("tickq_b", exp_tick_q.size(), 0);

        // A bouncing key must not produce an event
        wait_until(s2 + 12);
        for (int n = 0; n < 10; n++) begin
            btn_start_n = 1'b0;
            repeat (3) @(negedge clk);
            btn_start_n = 1'b1;
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        chk("bounce_state", {30'b0, state}, ST_STOP);

        // Both keys in the same cycle while in RUN: start/stop wins
        key_down(1, 0, r3);
        push_range(r3 + 10, r3 + 33);
        wait_until(r3);
        chk("run3_state", {30'b0, state}, ST_RUN);
        wait_until(r3 + 2);
        key_up(1, 0);
        wait_until(r3 + 25);
        key_down(1, 1, sb);
        wait_until(sb);
        chk("both_state", {30'b0, state}, ST_STOP);
        chk("both_freeze", {31'b0, freeze}, 0);
        wait_until(r3 + 35);
        key_up(1, 1);
        wait_until(sb + 8);
        chk("both_hold", {30'b0, state}, ST_STOP);
        chk("both_freeze2", {31'b0, freeze}, 0);
        chk("tickq_d", exp_tick_q.size(), 0);

        // Lap in STOP: clear for one cycle and return to IDLE
        wait_until(sb + 12);
        key_down(0, 1, k);
        wait_until(k - 1);
        chk("clr_pre", {31'b0, clear}, 0);
        chk("clr_pre_state", {30'b0, state}, ST_STOP);
        wait_until(k);
        chk("clr_pulse", {31'b0, clear}, 1);
        chk("clr_state", {30'b0, state}, ST_IDLE);
        chk("clr_div", 32'(dut.div_q), 0);
        chk("clr_tick", {31'b0, tick}, 0);
        chk("clr_running", {31'b0, running}, 0);
        wait_until(k + 1);
        chk("clr_post", {31'b0, clear}, 0);
        wait_until(sb + 22);
        key_up(0, 1);

        // Restart from IDLE, enter LAP, then apply reset between clock edges
        wait_until(k + 12);
        key_down(1, 0, r4);
        push_range(r4 + 10, r4 + 25);
        wait_until(r4 + 2);
        key_up(1, 0);
        wait_until(r4 + 12);
        key_down(0, 1, la4);
        wait_until(r4 + 22);
        key_up(0, 1);
        wait_until(la4 + 5);
        chk("prerst_freeze", {31'b0, freeze}, 1);
        chk("prerst_state", {30'b0, state}, ST_LAP);
        reset_n = 1'b0;
        #1;
        chk("arst_state", {30'b0, state}, ST_IDLE);
        chk("arst_tick", {31'b0, tick}, 0);
        chk("arst_clear", {31'b0, clear}, 0);
        chk("arst_freeze", {31'b0, freeze}, 0);
        chk("arst_running", {31'b0, running}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_state", {30'b0, state}, ST_IDLE);
        chk("post_rst_div", 32'(dut.div_q), 0);
        chk("tickq_e", exp_tick_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
